clock_tick_gen: RTL and testbench

Parametrised multi-channel clock-enable generator, the successor to the fixed two-output clock divider. It produces `NUM_CH` independent single-cycle tick strobes from the system clock. Each channel has a divisor that is runtime-programmable and reset-initialised from a parameter. All logic stays in the `clk` domain; consumers use `tick` as a clock enable and never as a derived clock. It feeds display multiplexing, debouncing and slow-rate FSMs in the top module.

---
 rtl/clock_tick_gen.sv | 103 ++++++++++
 tb/tb_clock_tick_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_gen.sv
// clock_tick_gen
//   Multi-channel clock-enable generator. Each of NUM_CH channels owns a
//   runtime-programmable divisor and produces a registered one-cycle tick
//   strobe every div[i] cycles of clk. Consumers use tick as a clock enable
//   and never as a clock.
//
// Optional feature (macro CLKTICK_SQUARE_EN):
//   Defined   - sq[i] is a registered square wave with period div[i] and a
//               high phase of floor(div[i]/2) cycles, falling with tick[i].
//   Undefined - sq is tied to 0 and no square-wave logic is built.
//
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  asynchronous, active-low reset
//   en       in  global count enable (0 = hold counters, suppress ticks)
//   sync_clr in  synchronous clear of all counters/outputs (divisors kept)
//   wr_en    in  divisor write strobe
//   wr_ch    in  channel written (values >= NUM_CH are ignored)
//   wr_div   in  new divisor (0 halts the channel)
//   tick     out per-channel one-cycle strobe
//   sq       out per-channel square wave
module clock_tick_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 25,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {25'd20000000, 25'd200000},
  parameter int unsigned CH_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             hit;
    logic             clr;
    logic             last;

    // Out-of-range channel numbers never match any generated channel.
    assign hit  = wr_en && (wr_ch == CH_W'(i));
    assign clr  = sync_clr || hit;
    assign last = (cnt_q == div_q - CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        div_q  <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        if (hit) div_q <= wr_div;
        if (clr || (div_q == '0)) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else if (!en) begin
          tick_q <= 1'b0;
        end else if (last) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt_q  <= cnt_q + CNT_W'(1);
          tick_q <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;

`ifdef CLKTICK_SQUARE_EN
    logic             sq_q;
    logic [CNT_W-1:0] rise_at;

    // Rise at count ceil(D/2)-1 so the high phase is floor(D/2) cycles and
    // the fall coincides with tick rising (odd D gets the longer low phase).
    assign rise_at = div_q - (div_q >> 1) - CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sq_q <= 1'b0;
      end else if (clr || (div_q < CNT_W'(2))) begin
        sq_q <= 1'b0;
      end else if (en) begin
        if (last)                  sq_q <= 1'b0;
        else if (cnt_q == rise_at) sq_q <= 1'b1;
      end
    end

    assign sq[i] = sq_q;
`endif
  end

`ifndef CLKTICK_SQUARE_EN
  assign sq = '0;
`endif

endmodule

// File: tb/tb_clock_tick_gen.sv
module tb_clock_tick_gen;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CH_W   = 2;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd7, 8'd10, 8'd4};

  logic              clk;
  logic              reset;
  logic              en;
  logic              sync_clr;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  clock_tick_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_INIT(DIV_INIT),
    .CH_W    (CH_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync_clr(sync_clr),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .tick    (tick),
    .sq      (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: divisor and count of counting edges since last clear.
  int m_div   [NUM_CH];
  int m_phase [NUM_CH];
  logic [2*NUM_CH-1:0] exp_q[$];   // {sq, tick} expected after each edge

  function automatic logic sq_model(input int phase, input int d);
`ifdef CLKTICK_SQUARE_EN
    if (d < 2) return 1'b0;
    return (phase % d) >= (d - d / 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = int'(DIV_INIT[i*CNT_W +: CNT_W]);
      m_phase[i] = 0;
    end
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, push the expected result, wait for the edge.
  task automatic drive(input logic e, input logic sc, input logic we,
                       input logic [CH_W-1:0] wc, input logic [CNT_W-1:0] wd);
    logic [NUM_CH-1:0] et;
    logic [NUM_CH-1:0] es;
    logic hit;
    int   d_old;
    en = e; sync_clr = sc; wr_en = we; wr_ch = wc; wr_div = wd;
    for (int i = 0; i < NUM_CH; i++) begin
      hit   = we && (int'(wc) == i);
      d_old = m_div[i];
      if (hit) m_div[i] = int'(wd);
      et[i] = 1'b0;
      es[i] = 1'b0;
      if (sc || hit || d_old == 0) begin
        m_phase[i] = 0;
      end else begin
        if (e) begin
          m_phase[i]++;
          et[i] = (m_phase[i] % m_div[i]) == 0;
        end
        es[i] = sq_model(m_phase[i], m_div[i]);
      end
    end
    exp_q.push_back({es, et});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2*NUM_CH-1:0] e;
    checks++;
    if (tick !== '0 || sq !== '0) begin
      errors++;
      $display("FAIL reset_async: tick=%b sq=%b expected 0", tick, sq);
    end
    @(posedge clk); #1;
    checks++;
    if (tick !== '0 || sq !== '0) begin
      errors++;
      $display("FAIL reset_held: tick=%b sq=%b expected 0", tick, sq);
    end
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL default_run cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
  endtask

  task automatic test_write();
    logic [2*NUM_CH-1:0] e;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd3);   // perturb ch0 phase
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd4);   // write ch0 = 4 at edge k
    for (int c = 0; c < 14; c++) begin
      if (c > 0) drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL write_ch0 cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 2'd3, 8'd1);   // out-of-range channel, ignored
    for (int c = 0; c < 12; c++) begin
      if (c > 0) drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL write_oob cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
  endtask

  task automatic test_en_gap();
    logic [2*NUM_CH-1:0] e;
    int cyc;
    int t1;
    int t2;
    t1 = -1; t2 = -1; cyc = 0;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd5);
    void'(exp_q.pop_front());
    for (int c = 0; c < 20; c++) begin
      drive((c >= 7 && c < 10) ? 1'b0 : 1'b1, 1'b0, 1'b0, '0, '0);
      cyc++;
      if (tick[0] === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL en_gap cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
    checks++;
    if (t1 != 5 || t2 - t1 != 8) begin
      errors++;
      $display("FAIL en_gap_spacing: first=%0d spacing=%0d expected first=5 spacing=8", t1, t2 - t1);
    end
  endtask

  task automatic test_div_edge();
    logic [2*NUM_CH-1:0] e;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd1);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b1, 2'd1, 8'd0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e || tick[0] !== 1'b1 || tick[1] !== 1'b0 || sq[1:0] !== 2'b00) begin
        errors++;
        $display("FAIL div_1_0 cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
  endtask

  task automatic test_sync_clr();
    logic [2*NUM_CH-1:0] e;
    int both;
    both = 0;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd6);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b1, 2'd1, 8'd9);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 1'b0, '0, '0);     // sync_clr at edge k
    void'(exp_q.pop_front());
    for (int c = 1; c <= 40; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      if (tick[0] === 1'b1 && tick[1] === 1'b1) both++;
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL sync_clr k+%0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
    checks++;
    if (both != 2) begin
      errors++;
      $display("FAIL sync_coincide: joint ticks=%0d expected 2", both);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*NUM_CH-1:0] e;
    drive(1'b1, 1'b1, 1'b1, 2'd2, 8'd3);  // write and sync_clr together
    for (int c = 0; c < 12; c++) begin
      if (c > 0) drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL clr_and_write cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
  endtask

  task automatic test_square();
    logic [2*NUM_CH-1:0] e;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd6);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b1, 2'd1, 8'd7);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b1, 2'd2, 8'd2);
    void'(exp_q.pop_front());
    for (int c = 0; c < 22; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL square cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2*NUM_CH-1:0] e;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'd1);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 1'b1, 2'd1, 8'd6);
    void'(exp_q.pop_front());
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL pre_reset cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
    // ch0 ticking every cycle, ch1 square high (if enabled): pull reset mid-cycle
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tick !== '0 || sq !== '0) begin
      errors++;
      $display("FAIL async_reset: tick=%b sq=%b expected 0", tick, sq);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      checks++;
      if ({sq, tick} !== e) begin
        errors++;
        $display("FAIL post_reset cyc %0d: sq,tick=%b expected %b", c, {sq, tick}, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    #2 reset = 1'b0;
    #1;
    test_reset();
    test_write();
    test_en_gap();
    test_div_edge();
    test_sync_clr();
    test_back_to_back();
    test_square();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
